// File: rtl/uf_pkg.sv
// Shared definitions for the union-find engine: command encodings, controller
// states and the parameter rule relating rank width to node id width.
package uf_pkg;

    typedef enum logic [1:0] {
        UF_OP_CLEAR = 2'b00,
        UF_OP_UNION = 2'b01,
        UF_OP_FIND  = 2'b10,
        UF_OP_SAME  = 2'b11
    } uf_op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WALK,
        ST_MERGE,
        ST_RESP
    } uf_state_e;

    // Union by rank keeps rank <= log2(N) <= ADDR_WIDTH, so the rank field
    // only has to hold the value ADDR_WIDTH.
    function automatic bit uf_rank_width_ok(input int unsigned addr_width,
                                            input int unsigned rank_width);
        return rank_width >= $clog2(addr_width + 1);
    endfunction

endpackage

// File: rtl/union_find_engine_if.sv
// Command/response bundle of the union-find engine. The engine side uses the
// slave modport, the issuing agent uses master.
interface union_find_engine_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_a;
    logic [ADDR_WIDTH-1:0] cmd_b;
    logic                  rsp_valid;
    logic [ADDR_WIDTH-1:0] rsp_root;
    logic                  rsp_same;
    logic                  rsp_merged;
    logic                  rsp_err;
    logic [ADDR_WIDTH:0]   num_sets;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_ready, rsp_valid, rsp_root, rsp_same, rsp_merged, rsp_err, num_sets
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_ready, rsp_valid, rsp_root, rsp_same, rsp_merged, rsp_err, num_sets
    );
endinterface

// File: rtl/uf_walker.sv
// One root-walk pointer. Advances one parent edge per step until it sits on a
// root, then latches that root. With UF_PATH_HALVING_EN defined, each non-root
// step also requests parent[x] <= parent[parent[x]].
module uf_walker #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_x,
    input  logic                  active,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] parent_x,
    input  logic [ADDR_WIDTH-1:0] grand_x,
    output logic [ADDR_WIDTH-1:0] x,
    output logic                  at_root,
    output logic [ADDR_WIDTH-1:0] root,
    output logic                  halve_en,
    output logic [ADDR_WIDTH-1:0] halve_addr,
    output logic [ADDR_WIDTH-1:0] halve_data
);
    logic [ADDR_WIDTH-1:0] x_q;
    logic [ADDR_WIDTH-1:0] root_q;
    logic                  done;
    logic                  self_loop;

    assign self_loop = (parent_x == x_q);

    // Pointer register: load on command accept, advance or latch root per step
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            root_q <= '0;
            done   <= 1'b0;
        end else if (load) begin
            x_q  <= load_x;
            done <= 1'b0;
        end else if (step && active && !done) begin
            if (self_loop) begin
                done   <= 1'b1;
                root_q <= x_q;
            end else begin
                x_q <= parent_x;
            end
        end
    end

    // Root status and halving write request for the current pointer position
    always_comb begin
        x          = x_q;
        at_root    = !active || done || self_loop;
        root       = done ? root_q : x_q;
        halve_addr = x_q;
        halve_data = grand_x;
`ifdef UF_PATH_HALVING_EN
        halve_en   = step && active && !done && !self_loop;
`else
        halve_en   = 1'b0;
`endif
    end

endmodule

// File: rtl/union_find_engine.sv
// Union-find (disjoint-set) engine: owns the parent/rank arrays, sequences
// INIT/IDLE/WALK/MERGE/RESP and applies the walkers' write requests.
// Optional feature macro: UF_PATH_HALVING_EN (path halving during walks).
module union_find_engine
    import uf_pkg::*;
#(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int RANK_WIDTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    union_find_engine_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH:0]   N_W      = (ADDR_WIDTH + 1)'(N);

    if (!uf_rank_width_ok(ADDR_WIDTH, RANK_WIDTH)) begin : g_rank_check
        $error("RANK_WIDTH too small for ADDR_WIDTH");
    end
    if ((64'd1 << ADDR_WIDTH) < 64'(N)) begin : g_addr_check
        $error("ADDR_WIDTH too small for N");
    end

    logic [ADDR_WIDTH-1:0] parent [N];
    logic [RANK_WIDTH-1:0] rank   [N];

    uf_state_e             state, state_next;
    logic [ADDR_WIDTH-1:0] init_idx;
    logic                  clear_pend;
    uf_op_e                op_q;
    logic [ADDR_WIDTH:0]   num_sets;
    logic [ADDR_WIDTH-1:0] rsp_root;
    logic                  rsp_same, rsp_merged, rsp_err;
    logic                  ready, rsp_valid;

    uf_op_e cmd_op_e;
    logic   accept, uses_b, cmd_err, load;
    logic   b_active;

    assign cmd_op_e = uf_op_e'(bus.cmd_op);
    assign accept   = bus.cmd_valid && ready;
    assign uses_b   = (cmd_op_e == UF_OP_UNION) || (cmd_op_e == UF_OP_SAME);
    assign cmd_err  = (cmd_op_e != UF_OP_CLEAR) &&
                      (({1'b0, bus.cmd_a} >= N_W) || (uses_b && ({1'b0, bus.cmd_b} >= N_W)));
    assign load     = accept && (cmd_op_e != UF_OP_CLEAR) && !cmd_err;
    assign b_active = (op_q == UF_OP_UNION) || (op_q == UF_OP_SAME);

    logic [ADDR_WIDTH-1:0] xa, xb, pa, pb, ga, gb, ra, rb;
    logic                  root_a, root_b, all_root;
    logic                  hw_en_a, hw_en_b;
    logic [ADDR_WIDTH-1:0] hw_addr_a, hw_addr_b, hw_data_a, hw_data_b;

    assign pa       = parent[xa];
    assign pb       = parent[xb];
    assign ga       = parent[pa];
    assign gb       = parent[pb];
    assign all_root = root_a && root_b;

    uf_walker #(.ADDR_WIDTH(ADDR_WIDTH)) u_walk_a (
        .clk(clk), .reset(reset), .load(load), .load_x(bus.cmd_a),
        .active(1'b1), .step(state == ST_WALK), .parent_x(pa), .grand_x(ga),
        .x(xa), .at_root(root_a), .root(ra),
        .halve_en(hw_en_a), .halve_addr(hw_addr_a), .halve_data(hw_data_a)
    );

    // FIND parks pointer b on operand a so its array reads stay in range.
    uf_walker #(.ADDR_WIDTH(ADDR_WIDTH)) u_walk_b (
        .clk(clk), .reset(reset), .load(load), .load_x(uses_b ? bus.cmd_b : bus.cmd_a),
        .active(b_active), .step(state == ST_WALK), .parent_x(pb), .grand_x(gb),
        .x(xb), .at_root(root_b), .root(rb),
        .halve_en(hw_en_b), .halve_addr(hw_addr_b), .halve_data(hw_data_b)
    );

    logic [RANK_WIDTH-1:0] rank_a, rank_b;
    logic [ADDR_WIDTH-1:0] survivor;

    assign rank_a   = rank[ra];
    assign rank_b   = rank[rb];
    assign survivor = (rank_a < rank_b) ? rb : ra;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (init_idx == LAST_IDX) state_next = clear_pend ? ST_RESP : ST_IDLE;
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op_e == UF_OP_CLEAR) state_next = ST_INIT;
                    else if (cmd_err)            state_next = ST_RESP;
                    else                         state_next = ST_WALK;
                end
            end
            ST_WALK:  if (all_root) state_next = (op_q == UF_OP_UNION) ? ST_MERGE : ST_RESP;
            ST_MERGE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_INIT;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        ready     = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: ready     = 1'b1;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Control registers: init sweep, command latch, response fields, set count
    always_ff @(posedge clk) begin
        if (reset) begin
            init_idx   <= '0;
            clear_pend <= 1'b0;
            op_q       <= UF_OP_CLEAR;
            num_sets   <= N_W;
            rsp_root   <= '0;
            rsp_same   <= 1'b0;
            rsp_merged <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_idx == LAST_IDX) begin
                        init_idx <= '0;
                        if (clear_pend) begin
                            clear_pend <= 1'b0;
                            rsp_root   <= '0;
                            rsp_same   <= 1'b0;
                            rsp_merged <= 1'b0;
                            rsp_err    <= 1'b0;
                        end
                    end else begin
                        init_idx <= init_idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= cmd_op_e;
                        if (cmd_op_e == UF_OP_CLEAR) begin
                            clear_pend <= 1'b1;
                            init_idx   <= '0;
                            num_sets   <= N_W;
                        end else if (cmd_err) begin
                            rsp_err    <= 1'b1;
                            rsp_root   <= '0;
                            rsp_same   <= 1'b0;
                            rsp_merged <= 1'b0;
                        end
                    end
                end
                ST_WALK: begin
                    if (all_root && op_q != UF_OP_UNION) begin
                        rsp_root   <= ra;
                        rsp_same   <= (op_q == UF_OP_SAME) && (ra == rb);
                        rsp_merged <= 1'b0;
                        rsp_err    <= 1'b0;
                    end
                end
                ST_MERGE: begin
                    rsp_root   <= survivor;
                    rsp_same   <= (ra == rb);
                    rsp_merged <= (ra != rb);
                    rsp_err    <= 1'b0;
                    if (ra != rb) num_sets <= num_sets - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Element storage: init sweep, halving writes during walks, merge link
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                parent[init_idx] <= init_idx;
                rank[init_idx]   <= '0;
            end else if (state == ST_WALK) begin
                if (hw_en_a) parent[hw_addr_a] <= hw_data_a;
                if (hw_en_b) parent[hw_addr_b] <= hw_data_b;
            end else if (state == ST_MERGE && ra != rb) begin
                if (rank_a < rank_b) begin
                    parent[ra] <= rb;
                end else begin
                    parent[rb] <= ra;
                    if (rank_a == rank_b) rank[ra] <= rank_a + 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready  = ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_root   = rsp_root;
    assign bus.rsp_same   = rsp_same;
    assign bus.rsp_merged = rsp_merged;
    assign bus.rsp_err    = rsp_err;
    assign bus.num_sets   = num_sets;

endmodule
